vcmac_seq: RTL

- Sequencer for the vector complex MAC datapath (N parallel CMAC lanes, multiply register plus accumulator).
- On `start`, it reads `len` operand words from the operand memory (base address `base_addr`, incrementing).
- It drives the datapath enables `w_en_mult`, `w_en_acc` and `acc` so the lanes compute a full complex dot product.
- It presents the result with a valid/ready handshake and a sticky overflow flag; it sits between the QFT control core and one vector MAC instance.

---
 rtl/vcmac_seq_if.sv | 51 +++++
 rtl/vcmac_seq.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/vcmac_seq_if.sv
`default_nettype none
// ============================================================================
//  Module      : vcmac_seq_if
//  Description : Bundle of the control, operand-memory, datapath-control and
//                result-handshake signals between the vector CMAC sequencer
//                and its environment.
//                master : the sequencer (drives strobes, result, status)
//                slave  : the environment (control core, memory, datapath)
//  Signals     : start, base_addr, len, abs_req, abort     control requests
//                busy, done                                status
//                rd_en, rd_addr                            operand memory read
//                mac_w_en_mult, mac_w_en_acc, mac_acc,
//                mac_abs, mac_overflow                     datapath control
//                res_valid, res_ready, ovf                 result handshake
//  Revision    : 1.0  initial release
// ============================================================================
interface vcmac_seq_if #(
    parameter int ADDR_W = 10,
    parameter int LEN_W  = 10
);
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [LEN_W-1:0]  len;
    logic              abs_req;
    logic              abort;
    logic              busy;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic              mac_w_en_mult;
    logic              mac_w_en_acc;
    logic              mac_acc;
    logic              mac_abs;
    logic              mac_overflow;
    logic              res_valid;
    logic              res_ready;
    logic              ovf;
    logic              done;

    modport master (
        input  start, base_addr, len, abs_req, abort, mac_overflow, res_ready,
        output busy, rd_en, rd_addr, mac_w_en_mult, mac_w_en_acc, mac_acc,
               mac_abs, res_valid, ovf, done
    );

    modport slave (
        output start, base_addr, len, abs_req, abort, mac_overflow, res_ready,
        input  busy, rd_en, rd_addr, mac_w_en_mult, mac_w_en_acc, mac_acc,
               mac_abs, res_valid, ovf, done
    );
endinterface
`default_nettype wire

// File: rtl/vcmac_seq.sv
`default_nettype none
// ============================================================================
//  Module      : vcmac_seq
//  Description : Sequencer for the vector complex MAC datapath. On an accepted
//                start it streams len operand reads from base_addr upward,
//                steers the datapath multiply/accumulate enables so the lanes
//                form a complete complex dot product, then offers the result
//                on a valid/ready handshake together with a sticky overflow.
//  Ports       : clk            clock, rising edge
//                rst_n          asynchronous reset, active low
//                bus (master)   see vcmac_seq_if
//  Parameters  : ADDR_W   operand memory address width
//                LEN_W    length field width (max len = 2^LEN_W-1)
//                MEM_LAT  operand memory read latency in cycles (>=1)
//  Options     : VCMAC_SEQ_ABS_EN  when defined, abs_req is latched on accept
//                                  and drives mac_abs while busy; otherwise
//                                  mac_abs is tied low.
//  Revision    : 1.0  initial release
// ============================================================================
module vcmac_seq #(
    parameter int ADDR_W  = 10,
    parameter int LEN_W   = 10,
    parameter int MEM_LAT = 1
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    vcmac_seq_if.master     bus
);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_RUN    = 2'd1;
    localparam logic [1:0] c_DRAIN  = 2'd2;
    localparam logic [1:0] c_RESULT = 2'd3;

    localparam logic [LEN_W-1:0]  c_LEN_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] c_ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;

    logic [ADDR_W-1:0] r_addr;
    logic [LEN_W-1:0]  r_len;
    logic [LEN_W-1:0]  r_idx;

    // Tag pipeline: bit j is the read issued j+1 cycles ago. The datapath
    // multiply stage sees data MEM_LAT cycles after the read, the
    // accumulate stage one cycle later.
    logic [MEM_LAT:0]  r_vld;
    logic [MEM_LAT:0]  r_first;

    logic              r_acc_d;     // previous cycle was an accumulate
    logic              r_ovf;
    logic              r_zdone;     // zero-length completion pulse
    logic              r_abs;

    logic              w_accept;
    logic              w_last;
    logic              w_drained;

    logic              w_busy;
    logic              w_rd_en;
    logic [ADDR_W-1:0] w_rd_addr;
    logic              w_mult;
    logic              w_acc_en;
    logic              w_acc;
    logic              w_abs;
    logic              w_res_valid;
    logic              w_ovf;
    logic              w_done;

    assign w_accept  = (r_state == c_IDLE) & bus.start & ~bus.abort;
    assign w_last    = (r_idx == (r_len - c_LEN_ONE));
    // Only the final accumulate may still be in flight when earlier stages
    // are empty; it completes this cycle, so the result is ready next cycle.
    assign w_drained = ~|r_vld[MEM_LAT-1:0];

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        if (bus.abort) begin
            w_state_nxt = c_IDLE;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (bus.start && (bus.len != '0)) begin
                        w_state_nxt = c_RUN;
                    end
                end
                c_RUN: begin
                    if (w_last) begin
                        w_state_nxt = c_DRAIN;
                    end
                end
                c_DRAIN: begin
                    if (w_drained) begin
                        w_state_nxt = c_RESULT;
                    end
                end
                c_RESULT: begin
                    if (bus.res_ready) begin
                        w_state_nxt = c_IDLE;
                    end
                end
                default: w_state_nxt = c_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output logic
    // ------------------------------------------------------------------
    always_comb begin
        w_busy      = (r_state != c_IDLE);
        w_rd_en     = (r_state == c_RUN);
        w_rd_addr   = w_rd_en ? r_addr : '0;
        w_mult      = r_vld[MEM_LAT-1];
        w_acc_en    = r_vld[MEM_LAT];
        w_acc       = r_vld[MEM_LAT] & ~r_first[MEM_LAT];
        w_res_valid = (r_state == c_RESULT);
        // Handshake completion is reported in the handshake cycle itself;
        // an abort in that cycle wins and suppresses it.
        w_done      = r_zdone | (w_res_valid & bus.res_ready & ~bus.abort);
        // The last accumulate's overflow arrives in the first result cycle,
        // so it is folded in combinationally to be visible with res_valid.
        w_ovf       = r_ovf | (r_acc_d & bus.mac_overflow);
        w_abs       = w_busy & r_abs;
    end

    assign bus.busy          = w_busy;
    assign bus.rd_en         = w_rd_en;
    assign bus.rd_addr       = w_rd_addr;
    assign bus.mac_w_en_mult = w_mult;
    assign bus.mac_w_en_acc  = w_acc_en;
    assign bus.mac_acc       = w_acc;
    assign bus.mac_abs       = w_abs;
    assign bus.res_valid     = w_res_valid;
    assign bus.ovf           = w_ovf;
    assign bus.done          = w_done;

    // ------------------------------------------------------------------
    // Address / count / tag pipeline / overflow
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr  <= '0;
            r_len   <= '0;
            r_idx   <= '0;
            r_vld   <= '0;
            r_first <= '0;
            r_acc_d <= 1'b0;
            r_ovf   <= 1'b0;
            r_zdone <= 1'b0;
        end else if (bus.abort) begin
            r_vld   <= '0;
            r_first <= '0;
            r_acc_d <= 1'b0;
            r_ovf   <= 1'b0;
            r_zdone <= 1'b0;
        end else begin
            r_vld   <= {r_vld[MEM_LAT-1:0], w_rd_en};
            r_first <= {r_first[MEM_LAT-1:0], w_rd_en & (r_idx == '0)};
            r_acc_d <= r_vld[MEM_LAT];
            r_zdone <= w_accept & (bus.len == '0);
            if (w_accept) begin
                r_addr <= bus.base_addr;
                r_len  <= bus.len;
                r_idx  <= '0;
                r_ovf  <= 1'b0;
            end else begin
                if (w_rd_en) begin
                    r_addr <= r_addr + c_ADDR_ONE;   // wraps modulo 2^ADDR_W
                    r_idx  <= r_idx + c_LEN_ONE;
                end
                if (r_acc_d && bus.mac_overflow) begin
                    r_ovf <= 1'b1;
                end
            end
        end
    end

`ifdef VCMAC_SEQ_ABS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_abs <= 1'b0;
        end else if (w_accept) begin
            r_abs <= bus.abs_req;
        end
    end
`else
    assign r_abs = 1'b0;
`endif

endmodule
`default_nettype wire
